// File: rtl/read_fsm_if.sv
// Bus bundle between the SRAM read sequencer and its requester/SRAM side.
// The slave modport is the sequencer; the master modport is whoever issues requests and returns SRAM data.
interface read_fsm_if #(
    parameter int data_width    = 16,
    parameter int address_width = 16,
    parameter int burst_width   = 4
);
    logic                     start;
    logic [address_width-1:0] input_address;
    logic [burst_width-1:0]   burst_length;
    logic [data_width-1:0]    sram_data;
    logic [address_width-1:0] sram_address;
    logic                     sram_cs;
    logic                     sram_oe;
    logic [data_width-1:0]    output_data;
    logic                     output_valid;
    logic                     done;

    modport master (
        output start, input_address, burst_length, sram_data,
        input  sram_address, sram_cs, sram_oe, output_data, output_valid, done
    );

    modport slave (
        input  start, input_address, burst_length, sram_data,
        output sram_address, sram_cs, sram_oe, output_data, output_valid, done
    );
endinterface

// File: rtl/read_fsm.sv
// SRAM read sequencer: latches address/burst on start, holds cs/oe low for wait_cycles per word,
// strobes each captured word, auto-increments the address, and ends with one turnaround cycle.
module read_fsm #(
    parameter int data_width    = 16,
    parameter int address_width = 16,
    parameter int wait_cycles   = 2,
    parameter int burst_width   = 4
) (
    input logic         clk,
    input logic         rst,
    read_fsm_if.slave   bus
);
    localparam int CW = (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(wait_cycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [CW-1:0]            r_wait;
    logic [burst_width-1:0]   r_remaining;
    logic [address_width-1:0] r_address;
    logic [data_width-1:0]    r_data;
    logic                     r_valid;
    logic                     w_accept;
    logic                     w_sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_sample = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = ACCESS;
                end
            end
            ACCESS: begin
                if (r_wait == LAST_WAIT) begin
                    w_sample = 1'b1;
                    if (r_remaining == '0) w_next = HOLD;
                end
            end
            HOLD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait      <= '0;
            r_remaining <= '0;
            r_address   <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= w_sample;
            if (w_accept) begin
                r_address   <= bus.input_address;
                r_remaining <= bus.burst_length;
                r_wait      <= '0;
            end else if (w_sample) begin
                r_data <= bus.sram_data;
                r_wait <= '0;
                // More words pending: advance without leaving ACCESS so cs/oe stay low.
                if (r_remaining != '0) begin
                    r_address   <= r_address + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                end
            end else if (r_state == ACCESS) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    assign bus.sram_address = r_address;
    assign bus.sram_cs      = (r_state != ACCESS);
    assign bus.sram_oe      = (r_state != ACCESS);
    assign bus.output_data  = r_data;
    assign bus.output_valid = r_valid;
    assign bus.done         = (r_state == IDLE);
endmodule

// File: tb/tb_read_fsm.sv
// Directed bench for read_fsm: per-cycle vector table plus burst, wrap and mid-burst reset sequences.
module tb_read_fsm;
    logic        clk;
    logic        rst;
    logic        use_xor;
    logic [15:0] fixed_data;
    int          checks;
    int          failures;

    read_fsm_if #(.data_width(16), .address_width(16), .burst_width(4)) bus ();

    read_fsm #(
        .data_width(16),
        .address_width(16),
        .wait_cycles(2),
        .burst_width(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // SRAM model: either a fixed word or address-derived data.
    assign bus.sram_data = use_xor ? (bus.sram_address ^ 16'h5555) : fixed_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        st;
        logic [15:0] a;
        logic [3:0]  bl;
        logic [15:0] dat;
        logic        cs;
        logic        oe;
        logic        dn;
        logic        vl;
        logic [15:0] od;
        logic [15:0] oa;
    } vec_t;

    vec_t        vt[12];
    logic [15:0] caps[32];
    int          cap_cyc[32];
    int          n_cap;
    int          done_cyc;
    int          cs_high;
    int          cnt;
    int          notdone;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Issues one request and observes until done returns (bounded).
    task automatic do_burst(input logic [15:0] a, input logic [3:0] bl);
        @(negedge clk);
        bus.start         = 1'b1;
        bus.input_address = a;
        bus.burst_length  = bl;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_cap    = 0;
        done_cyc = -1;
        cs_high  = 0;
        for (int c = 1; c < 64; c++) begin
            @(posedge clk);
            #1;
            if (bus.output_valid) begin
                caps[n_cap]    = bus.output_data;
                cap_cyc[n_cap] = c;
                n_cap++;
            end
            if (bus.done) begin
                done_cyc = c;
                break;
            end
            if (bus.sram_cs) cs_high++;
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        use_xor       = 1'b0;
        fixed_data    = 16'hA5A5;
        rst           = 1'b1;
        bus.start         = 1'b0;
        bus.input_address = 16'h0;
        bus.burst_length  = 4'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cs", 32'(bus.sram_cs), 32'd1);
        check("rst_oe", 32'(bus.sram_oe), 32'd1);
        check("rst_done", 32'(bus.done), 32'd1);
        check("rst_valid", 32'(bus.output_valid), 32'd0);
        check("rst_addr", 32'(bus.sram_address), 32'h0);
        check("rst_data", 32'(bus.output_data), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single read, then ignored start during ACCESS and back-to-back with start held high
        vt[0]  = '{1'b1, 16'h0010, 4'd0, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010};
        vt[1]  = '{1'b0, 16'h0000, 4'd0, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010};
        vt[2]  = '{1'b0, 16'h0000, 4'd0, 16'hA5A5, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA5A5, 16'h0010};
        vt[3]  = '{1'b0, 16'h0000, 4'd0, 16'hA5A5, 1'b1, 1'b1, 1'b1, 1'b0, 16'hA5A5, 16'h0010};
        vt[4]  = '{1'b1, 16'h0200, 4'd0, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, 16'h0200};
        vt[5]  = '{1'b1, 16'h0300, 4'd3, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, 16'h0200};
        vt[6]  = '{1'b1, 16'h0300, 4'd0, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1111, 16'h0200};
        vt[7]  = '{1'b1, 16'h0300, 4'd0, 16'h2222, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1111, 16'h0200};
        vt[8]  = '{1'b1, 16'h0300, 4'd0, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0300};
        vt[9]  = '{1'b0, 16'h0000, 4'd0, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0300};
        vt[10] = '{1'b0, 16'h0000, 4'd0, 16'h2222, 1'b1, 1'b1, 1'b0, 1'b1, 16'h2222, 16'h0300};
        vt[11] = '{1'b0, 16'h0000, 4'd0, 16'h2222, 1'b1, 1'b1, 1'b1, 1'b0, 16'h2222, 16'h0300};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.start         = vt[i].st;
            bus.input_address = vt[i].a;
            bus.burst_length  = vt[i].bl;
            fixed_data        = vt[i].dat;
            @(posedge clk);
            #1;
            check($sformatf("row%0d_cs", i), 32'(bus.sram_cs), 32'(vt[i].cs));
            check($sformatf("row%0d_oe", i), 32'(bus.sram_oe), 32'(vt[i].oe));
            check($sformatf("row%0d_done", i), 32'(bus.done), 32'(vt[i].dn));
            check($sformatf("row%0d_valid", i), 32'(bus.output_valid), 32'(vt[i].vl));
            check($sformatf("row%0d_data", i), 32'(bus.output_data), 32'(vt[i].od));
            check($sformatf("row%0d_addr", i), 32'(bus.sram_address), 32'(vt[i].oa));
        end
        bus.start = 1'b0;

        // Four-word burst with address-derived data
        use_xor = 1'b1;
        do_burst(16'h0100, 4'd3);
        check("burst_n", 32'(n_cap), 32'd4);
        check("burst_d0", 32'(caps[0]), 32'h5455);
        check("burst_d1", 32'(caps[1]), 32'h5454);
        check("burst_d2", 32'(caps[2]), 32'h5457);
        check("burst_d3", 32'(caps[3]), 32'h5456);
        for (int k = 0; k < 4; k++)
            check($sformatf("burst_cyc%0d", k), 32'(cap_cyc[k]), 32'((k + 1) * 2));
        check("burst_cs_gaps", 32'(cs_high), 32'd1);
        check("burst_done_cyc", 32'(done_cyc), 32'd9);
        check("burst_final_addr", 32'(bus.sram_address), 32'h0103);
        check("burst_data_held", 32'(bus.output_data), 32'h5456);

        // Address wrap
        do_burst(16'hFFFF, 4'd1);
        check("wrap_n", 32'(n_cap), 32'd2);
        check("wrap_d0", 32'(caps[0]), 32'hAAAA);
        check("wrap_d1", 32'(caps[1]), 32'h5555);
        check("wrap_done_cyc", 32'(done_cyc), 32'd5);
        check("wrap_addr", 32'(bus.sram_address), 32'h0000);

        // Reset during the second word of a four-word burst
        @(negedge clk);
        bus.start         = 1'b1;
        bus.input_address = 16'h0100;
        bus.burst_length  = 4'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_cs_before", 32'(bus.sram_cs), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_cs", 32'(bus.sram_cs), 32'd1);
        check("mid_rst_oe", 32'(bus.sram_oe), 32'd1);
        check("mid_rst_done", 32'(bus.done), 32'd1);
        check("mid_rst_valid", 32'(bus.output_valid), 32'd0);
        check("mid_rst_addr", 32'(bus.sram_address), 32'h0);
        check("mid_rst_data", 32'(bus.output_data), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        cnt     = 0;
        notdone = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus.output_valid) cnt++;
            if (!bus.done) notdone++;
        end
        check("post_rst_valids", 32'(cnt), 32'd0);
        check("post_rst_notdone", 32'(notdone), 32'd0);
        do_burst(16'h0040, 4'd0);
        check("post_rst_n", 32'(n_cap), 32'd1);
        check("post_rst_d0", 32'(caps[0]), 32'h5515);
        check("post_rst_cyc", 32'(cap_cyc[0]), 32'd2);
        check("post_rst_done_cyc", 32'(done_cyc), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
